// File: rtl/exec_pkg.sv
// Shared definitions for the execution datapath: ALU opcodes, table geometry
// and the reset contents of both lookup tables.
package exec_pkg;

    localparam int TBL_DEPTH = 32;
    localparam int KEY_W     = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_ASR  = 4'h7,
        OP_ROL  = 4'h8,
        OP_ROR  = 4'h9,
        OP_NOT  = 4'hA,
        OP_MOV  = 4'hB,
        OP_CMP  = 4'hC,
        OP_INC  = 4'hD,
        OP_DEC  = 4'hE,
        OP_PASS = 4'hF
    } alu_op_t;

    // Selects which reset-content function a table instance uses
    typedef enum logic {
        INIT_ACC,
        INIT_BRANCH
    } lut_init_t;

    // Accumulator-constant table: entry k holds the constant k
    function automatic logic [31:0] acc_lut_default(input int k);
        return 32'(k);
    endfunction

    // Branch-target table: every entry starts at address 0
    function automatic logic [31:0] branch_lut_default(input int k);
        return (k < 0) ? 32'd0 : 32'd0;
    endfunction

    function automatic logic [31:0] lut_default(input lut_init_t kind, input int k);
        return (kind == INIT_ACC) ? acc_lut_default(k) : branch_lut_default(k);
    endfunction

endpackage

// File: rtl/lut_table.sv
// 32-entry register-file lookup table with combinational gated read and a
// single synchronous write port. Reset reloads the selected default contents.
module lut_table
    import exec_pkg::*;
#(
    parameter int        W    = 8,
    parameter lut_init_t INIT = INIT_ACC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [KEY_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             en,
    input  logic [KEY_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [TBL_DEPTH];

    // Storage: reset reloads defaults and wins over a write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem[i] <= W'(lut_default(INIT, i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees pre-edge contents, so a same-cycle write returns the old value
    always_comb begin
        rdata = en ? mem[raddr] : '0;
    end

endmodule

// File: rtl/exec_unit.sv
// Execution datapath of the accumulator CPU: 8-bit ALU with registered
// Z/C/N/V status, plus the accumulator-constant and branch-target tables.
module exec_unit
    import exec_pkg::*;
#(
    parameter int PC_WIDTH = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_optype,
    input  logic [3:0]          alu_op,
    input  logic [7:0]          acc_in,
    input  logic [7:0]          reg_in,
    input  logic                flag_we,
    output logic [7:0]          alu_out,
    output logic                z,
    output logic                c,
    output logic                n,
    output logic                v,
    input  logic [KEY_W-1:0]    key,
    input  logic                acc_lut_en,
    output logic [7:0]          acc_lut_value,
    input  logic                branch_lut_en,
    output logic [PC_WIDTH:0]   branch_pos,
    input  logic                tbl_we,
    input  logic                tbl_sel,
    input  logic [KEY_W-1:0]    tbl_addr,
    input  logic [PC_WIDTH:0]   tbl_wdata
);

    alu_op_t     op;
    logic [7:0]  operand;
    logic [8:0]  add9;
    logic [8:0]  sub9;
    logic        v_add;
    logic        v_sub;
    logic [7:0]  res;
    logic [7:0]  zn_src;
    logic        c_nxt;
    logic        v_nxt;

    assign op = alu_op_t'(alu_op);

    // INC/DEC reuse the adder and subtractor with a constant operand of 1
    always_comb begin
        operand = (op == OP_INC || op == OP_DEC) ? 8'd1 : reg_in;
        add9    = {1'b0, acc_in} + {1'b0, operand};
        sub9    = {1'b0, acc_in} - {1'b0, operand};
        v_add   = (acc_in[7] == operand[7]) && (add9[7] != acc_in[7]);
        v_sub   = (acc_in[7] != operand[7]) && (sub9[7] != acc_in[7]);
    end

    // Result and next-status selection; CMP outputs acc but flags the difference
    always_comb begin
        res   = acc_in;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
        unique case (op)
            OP_ADD, OP_INC: begin
                res   = add9[7:0];
                c_nxt = add9[8];
                v_nxt = v_add;
            end
            OP_SUB, OP_DEC: begin
                res   = sub9[7:0];
                c_nxt = ~sub9[8];
                v_nxt = v_sub;
            end
            OP_CMP: begin
                res   = acc_in;
                c_nxt = ~sub9[8];
                v_nxt = v_sub;
            end
            OP_AND:  res = acc_in & reg_in;
            OP_OR:   res = acc_in | reg_in;
            OP_XOR:  res = acc_in ^ reg_in;
            OP_SHL: begin
                res   = {acc_in[6:0], 1'b0};
                c_nxt = acc_in[7];
            end
            OP_SHR: begin
                res   = {1'b0, acc_in[7:1]};
                c_nxt = acc_in[0];
            end
            OP_ASR: begin
                res   = {acc_in[7], acc_in[7:1]};
                c_nxt = acc_in[0];
            end
            OP_ROL: begin
                res   = {acc_in[6:0], acc_in[7]};
                c_nxt = acc_in[7];
            end
            OP_ROR: begin
                res   = {acc_in[0], acc_in[7:1]};
                c_nxt = acc_in[0];
            end
            OP_NOT:  res = ~acc_in;
            OP_MOV:  res = reg_in;
            OP_PASS: res = acc_in;
            default: res = acc_in;
        endcase
        zn_src = (op == OP_CMP) ? sub9[7:0] : res;
    end

    assign alu_out = alu_optype ? acc_in : res;

    // Status register: loads only on a strobed ALU-type instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            z <= 1'b0;
            c <= 1'b0;
            n <= 1'b0;
            v <= 1'b0;
        end else if (flag_we && !alu_optype) begin
            z <= (zn_src == 8'd0);
            c <= c_nxt;
            n <= zn_src[7];
            v <= v_nxt;
        end
    end

    lut_table #(
        .W    (8),
        .INIT (INIT_ACC)
    ) u_acc_lut (
        .clk   (clk),
        .reset (reset),
        .we    (tbl_we && !tbl_sel),
        .waddr (tbl_addr),
        .wdata (tbl_wdata[7:0]),
        .en    (acc_lut_en),
        .raddr (key),
        .rdata (acc_lut_value)
    );

    lut_table #(
        .W    (PC_WIDTH + 1),
        .INIT (INIT_BRANCH)
    ) u_branch_lut (
        .clk   (clk),
        .reset (reset),
        .we    (tbl_we && tbl_sel),
        .waddr (tbl_addr),
        .wdata (tbl_wdata),
        .en    (branch_lut_en),
        .raddr (key),
        .rdata (branch_pos)
    );

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU results and flags, flag hold conditions,
// table reads, writes, enables and reset interaction.
module tb_exec_unit;

    localparam int PC_WIDTH = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic                alu_optype;
    logic [3:0]          alu_op;
    logic [7:0]          acc_in;
    logic [7:0]          reg_in;
    logic                flag_we;
    logic [7:0]          alu_out;
    logic                z, c, n, v;
    logic [4:0]          key;
    logic                acc_lut_en;
    logic [7:0]          acc_lut_value;
    logic                branch_lut_en;
    logic [PC_WIDTH:0]   branch_pos;
    logic                tbl_we;
    logic                tbl_sel;
    logic [4:0]          tbl_addr;
    logic [PC_WIDTH:0]   tbl_wdata;

    int checks   = 0;
    int failures = 0;

    exec_unit #(.PC_WIDTH(PC_WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_optype    (alu_optype),
        .alu_op        (alu_op),
        .acc_in        (acc_in),
        .reg_in        (reg_in),
        .flag_we       (flag_we),
        .alu_out       (alu_out),
        .z             (z),
        .c             (c),
        .n             (n),
        .v             (v),
        .key           (key),
        .acc_lut_en    (acc_lut_en),
        .acc_lut_value (acc_lut_value),
        .branch_lut_en (branch_lut_en),
        .branch_pos    (branch_pos),
        .tbl_we        (tbl_we),
        .tbl_sel       (tbl_sel),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; alu_optype = 1'b0; alu_op = 4'h0; acc_in = 8'h00; reg_in = 8'h00;
        flag_we = 1'b0; key = 5'd0; acc_lut_en = 1'b0; branch_lut_en = 1'b0;
        tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = 5'd0; tbl_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        key = 5'd7; acc_lut_en = 1'b1; branch_lut_en = 1'b1;
        #1;
        checks++;
        if (acc_lut_value !== 8'd7) begin
            failures++;
            $display("FAIL reset_acc_lut got=%h want=07", acc_lut_value);
        end
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL reset_branch_lut got=%h want=000", branch_pos);
        end
        checks++;
        if ({z, c, n, v} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {z, c, n, v});
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] ops  [19] = '{4'h0, 4'h1, 4'hC, 4'h5, 4'h9, 4'h7, 4'h6, 4'h8, 4'h2, 4'h3,
                                  4'h4, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'hC};
        logic [7:0] accs [19] = '{8'hFF, 8'h80, 8'h05, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hF0, 8'h00,
                                  8'hFF, 8'h55, 8'h12, 8'h7F, 8'h00, 8'h80, 8'h7F, 8'h03, 8'h03};
        logic [7:0] regs [19] = '{8'h01, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00,
                                  8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h05};
        logic [7:0] outs [19] = '{8'h00, 8'h7F, 8'h05, 8'h02, 8'hC0, 8'hC0, 8'h40, 8'h03, 8'h30, 8'h00,
                                  8'hF0, 8'hAA, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h80, 8'hFE, 8'h03};
        logic [3:0] flgs [19] = '{4'b1100, 4'b0101, 4'b1100, 4'b0100, 4'b0110, 4'b0110, 4'b0100, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0010, 4'b0010, 4'b1000, 4'b0011, 4'b0010,
                                  4'b0010, 4'b0011, 4'b0010, 4'b0010};
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            alu_optype = 1'b0; alu_op = ops[i]; acc_in = accs[i]; reg_in = regs[i]; flag_we = 1'b1;
            #1;
            checks++;
            if (alu_out !== outs[i]) begin
                failures++;
                $display("FAIL alu_out[%0d] op=%h got=%h want=%h", i, ops[i], alu_out, outs[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({z, c, n, v} !== flgs[i]) begin
                failures++;
                $display("FAIL alu_flags[%0d] op=%h zcnv got=%b want=%b", i, ops[i], {z, c, n, v}, flgs[i]);
            end
        end
        @(negedge clk);
        flag_we = 1'b0;
    endtask

    task automatic test_flag_hold();
        // flags are 0010 from the last CMP; a strobe-less ADD must not disturb them
        @(negedge clk);
        alu_optype = 1'b0; alu_op = 4'h0; acc_in = 8'hFF; reg_in = 8'h01; flag_we = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({z, c, n, v} !== 4'b0010) begin
            failures++;
            $display("FAIL hold_no_we got=%b want=0010", {z, c, n, v});
        end
        // non-ALU instruction: result is acc and the strobe is ignored
        @(negedge clk);
        alu_optype = 1'b1; alu_op = 4'hB; acc_in = 8'h5A; reg_in = 8'h11; flag_we = 1'b1;
        #1;
        checks++;
        if (alu_out !== 8'h5A) begin
            failures++;
            $display("FAIL optype1_out got=%h want=5a", alu_out);
        end
        @(negedge clk);
        alu_op = 4'h0; acc_in = 8'h00; reg_in = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if ({z, c, n, v} !== 4'b0010) begin
            failures++;
            $display("FAIL optype1_flags got=%b want=0010", {z, c, n, v});
        end
        @(negedge clk);
        alu_optype = 1'b0; flag_we = 1'b0;
    endtask

    task automatic test_table_write();
        @(negedge clk);
        branch_lut_en = 1'b1; acc_lut_en = 1'b1; key = 5'd3;
        tbl_we = 1'b1; tbl_sel = 1'b1; tbl_addr = 5'd3; tbl_wdata = 12'h04D;
        #1;
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL branch_same_cycle got=%h want=000", branch_pos);
        end
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        #1;
        checks++;
        if (branch_pos !== 12'h04D) begin
            failures++;
            $display("FAIL branch_after_write got=%h want=04d", branch_pos);
        end
        checks++;
        if (acc_lut_value !== 8'd3) begin
            failures++;
            $display("FAIL acc_untouched_by_branch_write got=%h want=03", acc_lut_value);
        end
        @(negedge clk);
        branch_lut_en = 1'b0;
        #1;
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL branch_disabled got=%h want=000", branch_pos);
        end
        // acc table keeps only the low byte of the write data
        @(negedge clk);
        branch_lut_en = 1'b1; key = 5'd9;
        tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = 5'd9; tbl_wdata = 12'h1A5;
        #1;
        checks++;
        if (acc_lut_value !== 8'd9) begin
            failures++;
            $display("FAIL acc_same_cycle got=%h want=09", acc_lut_value);
        end
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        #1;
        checks++;
        if (acc_lut_value !== 8'hA5) begin
            failures++;
            $display("FAIL acc_after_write got=%h want=a5", acc_lut_value);
        end
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL branch_untouched_by_acc_write got=%h want=000", branch_pos);
        end
        @(negedge clk);
        acc_lut_en = 1'b0;
        #1;
        checks++;
        if (acc_lut_value !== 8'h00) begin
            failures++;
            $display("FAIL acc_disabled got=%h want=00", acc_lut_value);
        end
    endtask

    task automatic test_both_enables();
        @(negedge clk);
        acc_lut_en = 1'b1; branch_lut_en = 1'b1; key = 5'd3;
        #1;
        checks++;
        if (acc_lut_value !== 8'd3 || branch_pos !== 12'h04D) begin
            failures++;
            $display("FAIL both_enables got acc=%h br=%h want acc=03 br=04d", acc_lut_value, branch_pos);
        end
    endtask

    task automatic test_write_with_reset();
        @(negedge clk);
        reset = 1'b1; tbl_we = 1'b1; tbl_sel = 1'b1; tbl_addr = 5'd5; tbl_wdata = 12'h123;
        alu_optype = 1'b0; alu_op = 4'h0; acc_in = 8'hFF; reg_in = 8'h01; flag_we = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; tbl_we = 1'b0; flag_we = 1'b0;
        acc_lut_en = 1'b1; branch_lut_en = 1'b1; key = 5'd5;
        #1;
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL write_during_reset got=%h want=000", branch_pos);
        end
        key = 5'd3;
        #1;
        checks++;
        if (branch_pos !== 12'h000) begin
            failures++;
            $display("FAIL branch_reload got=%h want=000", branch_pos);
        end
        key = 5'd9;
        #1;
        checks++;
        if (acc_lut_value !== 8'd9) begin
            failures++;
            $display("FAIL acc_reload got=%h want=09", acc_lut_value);
        end
        checks++;
        if ({z, c, n, v} !== 4'b0000) begin
            failures++;
            $display("FAIL flags_reset_priority got=%b want=0000", {z, c, n, v});
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_flag_hold();
        test_table_write();
        test_both_enables();
        test_write_with_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
